seg_scan_capture: RTL

//  Receive side of the multiplexed 4-digit 7-segment bus (seg/dp/an0..an3, all active-low).

---
 rtl/seg_scan_capture_if.sv | 13 +
 rtl/seg_scan_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture_if.sv
// Multiplexed 4-digit 7-segment display bus (all lines active-low).
// The master drives the bus. seg_scan_capture listens on the slave side.
interface seg_scan_capture_if;
    logic [6:0] seg;
    logic       dp;
    logic       an0;
    logic       an1;
    logic       an2;
    logic       an3;

    modport master (output seg, dp, an0, an1, an2, an3);
    modport slave  (input  seg, dp, an0, an1, an2, an3);
endinterface

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive side of a scanned 4-digit 7-segment bus.
// The bus is asynchronous and passes through a 2-flop synchronizer.
// A digit is accepted once its anode/segment word has held steady for
// STABLE_CYC further cycles. Its segment pattern is then decoded back to a
// hex nibble, and a pulse flags each completed four-digit frame.
module seg_scan_capture #(
    parameter int STABLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_capture_if.slave bus,
    output logic [3:0]        num0,
    output logic [3:0]        num1,
    output logic [3:0]        num2,
    output logic [3:0]        num3,
    output logic [3:0]        digit_valid,
    output logic [3:0]        dp_seen,
    output logic              frame_done,
    output logic              bad_pattern,
    output logic              scan_err
);

    localparam int              TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYC);
    localparam logic [7:0]      STAB_TGT = 8'(STABLE_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Returns {hit, nibble} for an active-high gfedcba pattern; hit=0 when the
    // pattern is not one of the sixteen hex glyphs.
    function automatic logic [4:0] hex_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h6F:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h7C:   res = {1'b1, 4'hB};
            7'h39:   res = {1'b1, 4'hC};
            7'h5E:   res = {1'b1, 4'hD};
            7'h79:   res = {1'b1, 4'hE};
            7'h71:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    // Bus word layout: {an3, an2, an1, an0, dp, seg[6:0]}
    logic [11:0]     raw_s;
    logic [11:0]     sync1_r;
    logic [11:0]     sync2_r;
    logic [11:0]     prev_r;
    logic [7:0]      stab_cnt_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [3:0]      captured_r;
    state_t          state_r;

    logic [3:0]      s_an_s;
    logic            s_dp_s;
    logic [6:0]      s_seg_s;
    logic [7:0]      stab_next_s;
    logic [TO_W-1:0] to_next_s;
    logic            an_changed_s;
    logic            single_s;
    logic            none_s;
    logic            multi_s;
    logic [1:0]      idx_s;
    logic            can_accept_s;
    logic            accept_s;
    logic            dec_ok_s;
    logic [3:0]      dec_val_s;
    logic [3:0]      cap_next_s;

    assign raw_s = {bus.an3, bus.an2, bus.an1, bus.an0, bus.dp, bus.seg};

    // Decode the synced word: anode class, stability count, accept decision, timeout count.
    always_comb begin
        s_an_s       = sync2_r[11:8];
        s_dp_s       = sync2_r[7];
        s_seg_s      = sync2_r[6:0];
        an_changed_s = (sync2_r[11:8] != prev_r[11:8]);
        single_s     = 1'b0;
        none_s       = 1'b0;
        multi_s      = 1'b0;
        idx_s        = 2'd0;

        if (sync2_r != prev_r) begin
            stab_next_s = 8'd0;
        end else if (stab_cnt_r == 8'hFF) begin
            stab_next_s = 8'hFF;
        end else begin
            stab_next_s = stab_cnt_r + 8'd1;
        end

        case (s_an_s)
            4'b1110: begin single_s = 1'b1; idx_s = 2'd0; end
            4'b1101: begin single_s = 1'b1; idx_s = 2'd1; end
            4'b1011: begin single_s = 1'b1; idx_s = 2'd2; end
            4'b0111: begin single_s = 1'b1; idx_s = 2'd3; end
            4'b1111: none_s  = 1'b1;
            default: multi_s = 1'b1;
        endcase

        // In HOLD the digit was already taken; only a new anode reopens capture.
        can_accept_s = single_s && ((state_r != HOLD) || an_changed_s);
        // The count being written this edge is compared, giving STABLE_CYC+3 latency.
        accept_s     = can_accept_s && (stab_next_s == STAB_TGT);

        if (accept_s) begin
            to_next_s = {TO_W{1'b0}};
        end else if (to_cnt_r == TO_MAX) begin
            to_next_s = TO_MAX;
        end else begin
            to_next_s = to_cnt_r + TO_W'(1);
        end

        {dec_ok_s, dec_val_s} = hex_decode(~s_seg_s);
        cap_next_s            = captured_r | (4'b0001 << idx_s);
    end

    // Synchronizer, previous-word register, stability and timeout counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r    <= 12'hFFF;
            sync2_r    <= 12'hFFF;
            prev_r     <= 12'hFFF;
            stab_cnt_r <= 8'd0;
            to_cnt_r   <= {TO_W{1'b0}};
        end else begin
            sync1_r    <= raw_s;
            sync2_r    <= sync1_r;
            prev_r     <= sync2_r;
            stab_cnt_r <= stab_next_s;
            to_cnt_r   <= to_next_s;
        end
    end

    // Scan FSM with registered capture, frame tracking and error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            num0        <= 4'h0;
            num1        <= 4'h0;
            num2        <= 4'h0;
            num3        <= 4'h0;
            digit_valid <= 4'b0000;
            dp_seen     <= 4'b0000;
            captured_r  <= 4'b0000;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
            scan_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (multi_s) begin
                state_r  <= IDLE;
                scan_err <= 1'b1;
            end else if (none_s) begin
                state_r <= IDLE;
            end else if (accept_s) begin
                state_r         <= HOLD;
                scan_err        <= 1'b0;
                dp_seen[idx_s]  <= ~s_dp_s;
                if (dec_ok_s) begin
                    digit_valid[idx_s] <= 1'b1;
                    case (idx_s)
                        2'd0:    num0 <= dec_val_s;
                        2'd1:    num1 <= dec_val_s;
                        2'd2:    num2 <= dec_val_s;
                        2'd3:    num3 <= dec_val_s;
                        default: num0 <= num0;
                    endcase
                end else begin
                    bad_pattern <= 1'b1;
                end
                // The completing digit closes the frame; the next frame starts empty.
                if (cap_next_s == 4'b1111) begin
                    frame_done <= 1'b1;
                    captured_r <= 4'b0000;
                end else begin
                    captured_r <= cap_next_s;
                end
            end else if (can_accept_s) begin
                state_r <= SETTLE;
            end else begin
                state_r <= state_r;
            end

            // Timeout is raised once to_cnt reaches the limit and held while it saturates.
            if (!accept_s && (to_next_s == TO_MAX)) begin
                scan_err <= 1'b1;
            end
        end
    end

endmodule
